// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet receive definitions.
//   - preamble / SFD byte values
//   - CRC-32 polynomial, init value, good-frame residue and byte-wise update
//   - out_err bit indices
//   - deframer state encodings
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  localparam int ERR_FCS      = 0;
  localparam int ERR_RXER     = 1;
  localparam int ERR_RUNT     = 2;
  localparam int ERR_OVERSIZE = 3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PRE  = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_DROP = 2'd3;

  // MSB-first shift register fed with each byte LSB first, matching the
  // GMII bit order; with this register orientation a frame that includes
  // a correct FCS leaves CRC_RESIDUE behind.
  function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc,
                                                input logic [7:0]  data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: registered byte-wise Ethernet CRC-32.
//   clk  : clock
//   rst  : synchronous active-high reset, loads CRC_INIT
//   init : reload CRC_INIT (takes priority over en)
//   en   : fold data into the running CRC
//   data : byte to fold in
//   crc  : running CRC register
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_d8_next(crc, data);
    end
  end

endmodule

// File: rtl/gmii_rx_deframer.sv
// gmii_rx_deframer: strips preamble/SFD and FCS from a GMII receive stream.
//   clk, rst                 : clock, synchronous active-high reset
//   rxd, rxdv, rxer          : GMII receive inputs
//   out_data/valid/sop/eop   : destination address .. last byte before FCS
//   out_err                  : {oversize, runt, rxer seen, FCS bad}, with eop
//   cnt_ok, cnt_err          : saturating good / errored frame counters
// Bytes after SFD pass through a 5-byte delay line so the 4 FCS bytes are
// still held (and dropped) when rxdv falls; output latency is fixed.
module gmii_rx_deframer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxd,
  input  logic        rxdv,
  input  logic        rxer,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic [3:0]  out_err,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_err
);

  state_t      state_reg, state_next;
  logic        rxdv_prev_reg;
  logic [7:0]  dl_reg [5];
  logic [11:0] byte_cnt_reg;
  logic        rxer_reg, rxer_next;
  logic        sop_pending_reg;
  logic [31:0] crc;

  logic        push, emit, eop, discard, start_frame, have_full;
  logic [3:0]  err;

  eth_crc32_d8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (start_frame),
    .en   (push),
    .data (rxd),
    .crc  (crc)
  );

  // Once 5 bytes are held the delay line stays full for the rest of the frame.
  assign have_full = (byte_cnt_reg >= 12'd5);

  always_comb begin
    state_next  = state_reg;
    rxer_next   = rxer_reg;
    push        = 1'b0;
    emit        = 1'b0;
    eop         = 1'b0;
    discard     = 1'b0;
    start_frame = 1'b0;
    err         = 4'b0000;
    case (state_reg)
      ST_IDLE: begin
        rxer_next = 1'b0;
        // Only a genuine rxdv rising edge may start a frame; joining a frame
        // mid-stream (e.g. after reset) goes to DROP.
        if (rxdv) begin
          state_next = (rxd == PREAMBLE_BYTE && !rxdv_prev_reg) ? ST_PRE : ST_DROP;
        end
      end
      ST_PRE: begin
        rxer_next = rxer_reg | rxer;
        if (!rxdv) begin
          state_next = ST_IDLE;
        end else if (rxd == SFD_BYTE) begin
          state_next  = ST_DATA;
          start_frame = 1'b1;
        end else if (rxd != PREAMBLE_BYTE) begin
          state_next = ST_DROP;
        end
      end
      ST_DATA: begin
        rxer_next = rxer_reg | rxer;
        if (rxdv) begin
          push = 1'b1;
          emit = have_full;
          // The byte being sampled would push the length past MAX_FRAME:
          // close the frame on the oldest held byte and drop the rest.
          if (have_full && 32'(byte_cnt_reg) >= MAX_FRAME) begin
            eop               = 1'b1;
            err[ERR_OVERSIZE] = 1'b1;
            err[ERR_RXER]     = rxer_next;
            state_next        = ST_DROP;
          end
        end else begin
          state_next = ST_IDLE;
          if (have_full) begin
            emit              = 1'b1;
            eop               = 1'b1;
            err[ERR_FCS]      = (crc != CRC_RESIDUE);
            err[ERR_RXER]     = rxer_next;
            err[ERR_RUNT]     = (32'(byte_cnt_reg) < MIN_FRAME);
            err[ERR_OVERSIZE] = (32'(byte_cnt_reg) > MAX_FRAME);
          end else begin
            discard = 1'b1;
          end
        end
      end
      default: begin
        if (!rxdv) state_next = ST_IDLE;
      end
    endcase
  end

  // Delay line: dl_reg[0] newest, dl_reg[4] oldest.
  for (genvar gi = 0; gi < 5; gi++) begin : g_dl
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst)       dl_reg[gi] <= 8'h00;
        else if (push) dl_reg[gi] <= rxd;
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (rst)       dl_reg[gi] <= 8'h00;
        else if (push) dl_reg[gi] <= dl_reg[gi-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    // Tracks rxdv through reset so a frame in flight at release is seen as
    // already started.
    rxdv_prev_reg <= rxdv;
    if (rst) begin
      state_reg       <= ST_IDLE;
      byte_cnt_reg    <= 12'd0;
      rxer_reg        <= 1'b0;
      sop_pending_reg <= 1'b0;
      out_data        <= 8'h00;
      out_valid       <= 1'b0;
      out_sop         <= 1'b0;
      out_eop         <= 1'b0;
      out_err         <= 4'b0000;
      cnt_ok          <= 16'h0000;
      cnt_err         <= 16'h0000;
    end else begin
      state_reg <= state_next;
      rxer_reg  <= rxer_next;

      if (start_frame) begin
        byte_cnt_reg <= 12'd0;
      end else if (push && byte_cnt_reg != 12'hFFF) begin
        byte_cnt_reg <= byte_cnt_reg + 12'd1;
      end

      if (start_frame)  sop_pending_reg <= 1'b1;
      else if (emit)    sop_pending_reg <= 1'b0;

      out_valid <= emit;
      out_data  <= emit ? dl_reg[4] : 8'h00;
      out_sop   <= emit && sop_pending_reg;
      out_eop   <= eop;
      out_err   <= err;

      if (eop && err == 4'b0000 && cnt_ok != 16'hFFFF) begin
        cnt_ok <= cnt_ok + 16'd1;
      end
      if (((eop && err != 4'b0000) || discard) && cnt_err != 16'hFFFF) begin
        cnt_err <= cnt_err + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed testbench for gmii_rx_deframer.
module tb_gmii_rx_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxd;
  logic        rxdv;
  logic        rxer;
  logic [7:0]  out_data;
  logic        out_valid, out_sop, out_eop;
  logic [3:0]  out_err;
  logic [15:0] cnt_ok, cnt_err;

  gmii_rx_deframer #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rxdv      (rxdv),
    .rxer      (rxer),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_err   (out_err),
    .cnt_ok    (cnt_ok),
    .cnt_err   (cnt_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output capture
  logic [7:0] cap_data [4096];
  logic       cap_sop  [4096];
  logic       cap_eop  [4096];
  logic [3:0] cap_err  [4096];
  int         cap_cyc  [4096];
  int         cap_n    = 0;
  int         err_leak = 0;

  always @(negedge clk) begin
    if (out_valid && cap_n < 4096) begin
      cap_data[cap_n] <= out_data;
      cap_sop[cap_n]  <= out_sop;
      cap_eop[cap_n]  <= out_eop;
      cap_err[cap_n]  <= out_err;
      cap_cyc[cap_n]  <= cyc;
      cap_n           <= cap_n + 1;
    end
    if ((!out_eop && out_err != 4'b0000) || (out_eop && !out_valid)) begin
      err_leak <= err_leak + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] frm     [1604];
  int         drv_cyc [1604];
  int         end_cyc;
  int         frm_len;
  int         base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic dv, input logic [7:0] d, input logic er, input logic r);
    @(posedge clk);
    #1;
    rxdv = dv;
    rxd  = d;
    rxer = er;
    rst  = r;
  endtask

  task automatic build(input int len, input int seed);
    for (int i = 0; i < len; i++) frm[i] = 8'(i * 13 + seed * 29);
    frm_len = len;
  endtask

  // Standard reflected Ethernet CRC, FCS sent least significant byte first.
  task automatic append_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < frm_len; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    frm[frm_len]   = c[7:0];
    frm[frm_len+1] = c[15:8];
    frm[frm_len+2] = c[23:16];
    frm[frm_len+3] = c[31:24];
    frm_len = frm_len + 4;
  endtask

  task automatic send_frame(input int rxer_at, input int rst_at);
    for (int i = 0; i < 7; i++) step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < frm_len; i++) begin
      step(1'b1, frm[i], (i == rxer_at), (i == rst_at));
      drv_cyc[i] = cyc;
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    end_cyc = cyc;
    repeat (12) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int b, input int exp_n,
                             input int exp_eops, input logic [3:0] exp_err);
    int n, sops, eops, data_bad, lat_bad, want;
    n = cap_n - b;
    sops = 0; eops = 0; data_bad = 0; lat_bad = 0;
    for (int j = 0; j < n; j++) begin
      if (cap_sop[b+j]) sops++;
      if (cap_eop[b+j]) eops++;
      if (cap_data[b+j] !== frm[j]) data_bad++;
      want = (j + 5 < frm_len) ? drv_cyc[j+5] + 1 : end_cyc + 1;
      if (cap_cyc[b+j] != want) lat_bad++;
    end
    chk({tag, ".count"}, 32'(n), 32'(exp_n));
    chk({tag, ".sops"}, 32'(sops), (exp_n > 0) ? 32'd1 : 32'd0);
    chk({tag, ".eops"}, 32'(eops), 32'(exp_eops));
    chk({tag, ".data"}, 32'(data_bad), 32'd0);
    chk({tag, ".latency"}, 32'(lat_bad), 32'd0);
    if (n > 0) chk({tag, ".first_sop"}, {31'd0, cap_sop[b]}, 32'd1);
    if (n > 0 && exp_eops > 0) begin
      chk({tag, ".last_eop"}, {31'd0, cap_eop[b+n-1]}, 32'd1);
      chk({tag, ".err"}, {28'd0, cap_err[b+n-1]}, {28'd0, exp_err});
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rxdv = 1'b0; rxd = 8'h00; rxer = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.out_sop",   {31'd0, out_sop},   32'd0);
    chk("reset.out_eop",   {31'd0, out_eop},   32'd0);
    chk("reset.out_err",   {28'd0, out_err},   32'd0);
    chk("reset.out_data",  {24'd0, out_data},  32'd0);
    chk("reset.cnt_ok",    {16'd0, cnt_ok},    32'd0);
    chk("reset.cnt_err",   {16'd0, cnt_err},   32'd0);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Good 60-byte frame
    build(60, 1); append_fcs(); base = cap_n; send_frame(-1, -1);
    check_frame("good1", base, 60, 1, 4'b0000);
    chk("good1.cnt_ok", {16'd0, cnt_ok}, 32'd1);
    chk("good1.cnt_err", {16'd0, cnt_err}, 32'd0);

    // Last FCS byte inverted
    build(60, 1); append_fcs(); frm[63] = ~frm[63]; base = cap_n; send_frame(-1, -1);
    check_frame("badfcs", base, 60, 1, 4'b0001);
    chk("badfcs.cnt_err", {16'd0, cnt_err}, 32'd1);

    // 20-byte runt with valid FCS
    build(16, 2); append_fcs(); base = cap_n; send_frame(-1, -1);
    check_frame("runt20", base, 16, 1, 4'b0100);
    chk("runt20.cnt_err", {16'd0, cnt_err}, 32'd2);

    // 3 bytes after SFD: silent discard
    build(3, 3); base = cap_n; send_frame(-1, -1);
    check_frame("short3", base, 0, 0, 4'b0000);
    chk("short3.cnt_err", {16'd0, cnt_err}, 32'd3);

    // 1600-byte frame truncated at MAX_FRAME
    build(1600, 4); base = cap_n; send_frame(-1, -1);
    check_frame("oversize", base, 1514, 1, 4'b1000);
    chk("oversize.cnt_err", {16'd0, cnt_err}, 32'd4);

    // Good frame after oversize
    build(60, 5); append_fcs(); base = cap_n; send_frame(-1, -1);
    check_frame("good2", base, 60, 1, 4'b0000);
    chk("good2.cnt_ok", {16'd0, cnt_ok}, 32'd2);

    // rxer on byte 10
    build(60, 6); append_fcs(); base = cap_n; send_frame(10, -1);
    check_frame("rxer10", base, 60, 1, 4'b0010);
    chk("rxer10.cnt_err", {16'd0, cnt_err}, 32'd5);

    // Minimum 5-byte frame: single sop+eop byte, runt
    build(1, 7); append_fcs(); base = cap_n; send_frame(-1, -1);
    check_frame("five", base, 1, 1, 4'b0100);
    chk("five.sop_eq_eop", {31'd0, cap_sop[base] & cap_eop[base]}, 32'd1);
    chk("five.cnt_err", {16'd0, cnt_err}, 32'd6);

    // Reset on byte 30: 25 bytes out, no eop, remainder ignored
    build(60, 8); append_fcs(); base = cap_n; send_frame(-1, 30);
    check_frame("rstmid", base, 25, 0, 4'b0000);
    chk("rstmid.cnt_ok", {16'd0, cnt_ok}, 32'd0);
    chk("rstmid.cnt_err", {16'd0, cnt_err}, 32'd0);

    // Good frame after reset
    build(60, 9); append_fcs(); base = cap_n; send_frame(-1, -1);
    check_frame("good3", base, 60, 1, 4'b0000);
    chk("good3.cnt_ok", {16'd0, cnt_ok}, 32'd1);
    chk("good3.cnt_err", {16'd0, cnt_err}, 32'd0);

    chk("err_only_with_eop", 32'(err_leak), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gmii_rx_deframer.md
GMII_RX_DEFRAMER -- requirements
Module: gmii_rx_deframer

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 64: minimum legal frame length in bytes, destination address through FCS inclusive.
REQ-002 SHALL have parameter MAX_FRAME, default 1518: maximum legal frame length in bytes, same counting.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every signal is sampled on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port rxd, input, 8 bits: GMII receive data.
REQ-006 SHALL have port rxdv, input, 1 bit: GMII receive data valid.
REQ-007 SHALL have port rxer, input, 1 bit: GMII receive error.
REQ-008 SHALL have port out_data, output, 8 bits: payload byte, destination address through last byte before the FCS.
REQ-009 SHALL have ports out_valid, out_sop and out_eop, outputs, 1 bit each: byte strobe, first-byte marker and last-byte marker.
REQ-010 SHALL have port out_err, output, 4 bits, valid only with out_eop: bit0 FCS error, bit1 rxer seen, bit2 runt (length < MIN_FRAME), bit3 oversize (length > MAX_FRAME).
REQ-011 SHALL have ports cnt_ok and cnt_err, outputs, 16 bits each: count of good frames and of errored frames.
REQ-012 SHALL have no output backpressure; the consumer accepts every out_valid byte.

Function
REQ-013 SHALL implement four states: IDLE, PRE, DATA, DROP.
REQ-014 IDLE SHALL go to PRE when rxdv=1, rxd=0x55 and rxdv was 0 on the previous cycle; otherwise, with rxdv=1, it SHALL go to DROP.
REQ-015 PRE SHALL stay on 0x55, go to DATA on 0xD5 (SFD), go to DROP on any other byte, and go to IDLE when rxdv=0.
REQ-016 DATA SHALL push each byte into a 5-deep byte delay line and count bytes (12-bit counter, saturating).
REQ-017 When the delay line holds 5 bytes and a new byte arrives, the oldest byte SHALL be emitted with out_valid=1 the next cycle; out_sop SHALL be set on the first byte emitted.
REQ-018 On the first rxdv=0 cycle in DATA, the oldest held byte SHALL be emitted the next cycle with out_eop=1 and out_err set; the remaining 4 FCS bytes SHALL be discarded; the state SHALL go to IDLE.
REQ-019 A 5-byte frame SHALL produce a single byte with out_sop=out_eop=1.
REQ-020 A frame ending with fewer than 5 bytes after SFD SHALL emit nothing and SHALL increment cnt_err.
REQ-021 CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF) SHALL run over every byte after SFD, FCS included; the FCS is good iff the residue equals 0xC704DD7B.
REQ-022 rxer=1 on any cycle in PRE or DATA SHALL latch err bit1 for the current frame.
REQ-023 When the byte count exceeds MAX_FRAME, the oldest held byte SHALL be emitted with out_eop=1 and bit3 set, and the state SHALL go to DROP.
REQ-024 DROP SHALL discard input until rxdv=0, then go to IDLE.
REQ-025 cnt_ok SHALL increment on an eop with out_err=0, and cnt_err SHALL increment on an eop with out_err≠0 or on a silent discard; both SHALL saturate at 0xFFFF.
REQ-026 Output latency SHALL be fixed: byte N is emitted the cycle after byte N+5 is sampled, or the cycle after rxdv falls for the final byte.
REQ-027 out_valid SHALL never be asserted in two frames without an out_eop between them.

Reset
REQ-028 rst SHALL set state to IDLE, clear the delay line, byte count and error latches, drive out_valid/out_sop/out_eop/out_err to 0 and out_data to 0x00, and clear cnt_ok and cnt_err.
REQ-029 Reset mid-frame SHALL emit no eop; a frame still active at reset release SHALL be ignored until rxdv=0 is seen.

Structure
REQ-030 Package eth_pkg SHALL hold the preamble/SFD constants, CRC polynomial, init value and residue, the err bit indices and the state enum.
REQ-031 The byte-wise CRC-32 update SHALL be a sub-module eth_crc32_d8 (clk, rst, init, en, data, crc).

Verification
REQ-032 7x0x55 + 0xD5 + 60-byte payload + correct FCS -> 60 bytes out, sop on byte 0, eop on byte 59, out_err=0, cnt_ok=1.
REQ-033 Same frame with the last FCS byte flipped -> 60 bytes out, out_err=0b0001, cnt_err=1.
REQ-034 Preamble + SFD + 20 bytes (including FCS) -> 16 bytes out, out_err bit2 set; preamble + SFD + 3 bytes -> no output, cnt_err incremented.
REQ-035 1600-byte frame -> eop on the 1514th output byte with bit3 set, rest dropped; the next good frame is received normally.
REQ-036 rxer pulsed on byte 10 -> eop carries bit1; rst asserted on byte 30 of a frame -> no eop, the following good frame gives cnt_ok=1.
